// File: rtl/dq_rx_if.sv
// Output side of the dq receiver: first-word fall-through byte stream
// with a valid/ready handshake.
interface dq_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/dq_rx.sv
// dq_rx: samples the dqs_p/dqs_n/dq taps, decodes preamble, an 8-bit
// MSB-first burst and postamble, reports malformed bursts and queues
// received bytes in a small FWFT FIFO.
module dq_rx #(
  parameter int DEPTH   = 4,
  parameter int PRE_MIN = 2,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dqs_p,
  input  logic        dqs_n,
  input  logic        dq,
  dq_rx_if.master     rx,
  output logic        rx_err,
  output logic [1:0]  rx_err_code,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] PRE_LIM = CW'(PRE_MIN);

  typedef enum logic [2:0] {IDLE, PRE, BIT_HI, BIT_LO, POST} state_t;

  state_t          state;
  logic            s_p, s_n, s_dq;
  logic [CW-1:0]   lvl_cnt;
  logic [2:0]      bit_cnt;
  logic            last_h;
  logic [6:0]      shreg;

  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;

  logic            lvl_h, lvl_l;
  logic            push, pop, full, empty, ovf;

  assign lvl_h = s_p & ~s_n;
  assign lvl_l = ~s_p & s_n;

  // The 8th bit is an H arriving in BIT_LO with seven bits already shifted.
  assign push  = (state == BIT_LO) && lvl_h && (bit_cnt == 3'd7);
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = rx.rx_valid && rx.rx_ready;
  // A push into a full FIFO is only legal when a pop frees a slot that edge.
  assign ovf   = push && full && !pop;

  assign rx.rx_valid = ~empty;
  assign rx.rx_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign busy        = (state != IDLE);

  // Register the pin taps once; idle bus reads as H.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_p  <= 1'b1;
      s_n  <= 1'b0;
      s_dq <= 1'b0;
    end else begin
      s_p  <= dqs_p;
      s_n  <= dqs_n;
      s_dq <= dq;
    end
  end

  // Burst decoder FSM with level-duration counter and error reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lvl_cnt     <= '0;
      bit_cnt     <= '0;
      last_h      <= 1'b1;
      rx_err      <= 1'b0;
      rx_err_code <= 2'd0;
    end else begin
      rx_err <= 1'b0;
      if (ovf) begin
        rx_err      <= 1'b1;
        rx_err_code <= 2'd0;
      end
      if (state == IDLE) begin
        if (lvl_l) begin
          state   <= PRE;
          lvl_cnt <= CW'(1);
          last_h  <= 1'b0;
        end
      end else if (!lvl_h && !lvl_l) begin
        rx_err      <= 1'b1;
        rx_err_code <= 2'd2;
        bit_cnt     <= '0;
        state       <= IDLE;
      end else if (lvl_h == last_h) begin
        // Level held: keep counting until the strobe stalls too long.
        if (lvl_cnt >= TO_LAST) begin
          rx_err      <= 1'b1;
          rx_err_code <= 2'd3;
          bit_cnt     <= '0;
          state       <= IDLE;
        end else begin
          lvl_cnt <= lvl_cnt + CW'(1);
        end
      end else begin
        // Level change: restart the duration count and advance the protocol.
        last_h  <= lvl_h;
        lvl_cnt <= CW'(1);
        case (state)
          PRE: begin
            if (lvl_cnt >= PRE_LIM) begin
              shreg   <= {shreg[5:0], s_dq};
              bit_cnt <= 3'd1;
              state   <= BIT_HI;
            end else begin
              rx_err      <= 1'b1;
              rx_err_code <= 2'd1;
              state       <= IDLE;
            end
          end
          BIT_HI: state <= BIT_LO;
          BIT_LO: begin
            shreg   <= {shreg[5:0], s_dq};
            bit_cnt <= bit_cnt + 3'd1;
            state   <= (bit_cnt == 3'd7) ? POST : BIT_HI;
          end
          // POST is entered on H, so a change to H means the postamble L was seen.
          POST: if (lvl_h) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // FIFO storage and pointers; pointers carry an extra wrap bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && (!full || pop)) begin
        mem[wr_ptr[AW-1:0]] <= {shreg, s_dq};
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: tb/tb_dq_rx.sv
// Testbench for dq_rx: directed bursts, expected bytes and error codes go
// into scoreboard queues checked by an independent output monitor.
module tb_dq_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dqs_p = 1'b1;
  logic       dqs_n = 1'b0;
  logic       dq = 1'b0;
  logic       rx_err;
  logic [1:0] rx_err_code;
  logic       busy;

  dq_rx_if rxif ();

  dq_rx #(.DEPTH(4), .PRE_MIN(2), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .dqs_p       (dqs_p),
    .dqs_n       (dqs_n),
    .dq          (dq),
    .rx          (rxif),
    .rx_err      (rx_err),
    .rx_err_code (rx_err_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic [1:0] err_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Hold one pin pattern for exactly one clock, returning just after the edge.
  task automatic cyc(input logic p, input logic n, input logic d);
    dqs_p = p;
    dqs_n = n;
    dq    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic h_cyc(input logic d); cyc(1'b1, 1'b0, d); endtask
  task automatic l_cyc();              cyc(1'b0, 1'b1, 1'b0); endtask

  // Full burst: preamble, 8 bits (H then L each), release and two idle cycles.
  task automatic burst(input logic [7:0] b, input int pre, input bit store, input bit lat);
    if (store) exp_q.push_back(b);
    for (int i = 0; i < pre; i++) l_cyc();
    for (int i = 7; i >= 0; i--) begin
      h_cyc(b[i]);
      if (lat && i == 0) chk("valid_before_push", rxif.rx_valid, 0);
      l_cyc();
    end
    if (lat) begin
      chk("valid_latency", rxif.rx_valid, 1);
      chk("data_latency", rxif.rx_data, b);
      chk("err_clean", rx_err, 0);
    end
    h_cyc(1'b0);
    if (lat) chk("busy_post", busy, 1);
    h_cyc(1'b0);
    if (lat) chk("busy_release", busy, 0);
    h_cyc(1'b0);
  endtask

  // Monitor: compare every accepted byte and every error pulse with the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rxif.rx_valid && rxif.rx_ready) begin
          if (exp_q.size() == 0) chk("unexpected_byte", rxif.rx_data, 32'hFFFF_FFFF);
          else chk("rx_data", rxif.rx_data, exp_q.pop_front());
        end
        if (rx_err) begin
          if (err_q.size() == 0) chk("unexpected_err", rx_err_code, 32'hFFFF_FFFF);
          else chk("rx_err_code", rx_err_code, err_q.pop_front());
        end
      end
    end
  end

  initial begin
    rxif.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", rxif.rx_valid, 0);
    chk("rst_data", rxif.rx_data, 0);
    chk("rst_err", rx_err, 0);
    chk("rst_code", rx_err_code, 0);
    chk("rst_busy", busy, 0);
    repeat (2) h_cyc(1'b0);

    // Clean burst 0xA5 with latency/busy timing.
    burst(8'hA5, 2, 1'b1, 1'b1);

    // One-cycle preamble then H: short preamble error.
    err_q.push_back(2'd1);
    l_cyc();
    h_cyc(1'b0);
    chk("short_pre_not_yet", rx_err, 0);
    chk("short_pre_busy", busy, 1);
    h_cyc(1'b0);
    chk("short_pre_err", rx_err, 1);
    chk("short_pre_code", rx_err_code, 1);
    chk("short_pre_idle", busy, 0);
    chk("short_pre_valid", rxif.rx_valid, 0);
    repeat (3) h_cyc(1'b0);

    // Strobe contention after bit 3, then a clean 0x3C.
    err_q.push_back(2'd2);
    repeat (2) l_cyc();
    for (int i = 0; i < 3; i++) begin
      h_cyc(1'b1);
      l_cyc();
    end
    cyc(1'b1, 1'b1, 1'b0);
    h_cyc(1'b0);
    h_cyc(1'b0);
    chk("contention_code", rx_err_code, 2);
    chk("contention_idle", busy, 0);
    repeat (2) h_cyc(1'b0);
    burst(8'h3C, 3, 1'b1, 1'b0);

    // Strobe stalls low for 64 cycles in BIT_LO: timeout, no byte.
    err_q.push_back(2'd3);
    repeat (2) l_cyc();
    h_cyc(1'b1); l_cyc();
    h_cyc(1'b0); l_cyc();
    h_cyc(1'b1);
    repeat (64) l_cyc();
    chk("timeout_not_early", rx_err, 0);
    h_cyc(1'b0);
    chk("timeout_err", rx_err, 1);
    chk("timeout_code", rx_err_code, 3);
    chk("timeout_idle", busy, 0);
    chk("timeout_no_byte", rxif.rx_valid, 0);
    repeat (3) h_cyc(1'b0);

    // Reset during bit 5 with two bytes queued: everything is dropped.
    rxif.rx_ready = 1'b0;
    burst(8'h11, 2, 1'b1, 1'b0);
    burst(8'h22, 2, 1'b1, 1'b0);
    chk("queued_valid", rxif.rx_valid, 1);
    repeat (2) l_cyc();
    for (int i = 0; i < 4; i++) begin
      h_cyc(1'b1);
      l_cyc();
    end
    dqs_p = 1'b1; dqs_n = 1'b0; dq = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_valid", rxif.rx_valid, 0);
    chk("mid_rst_data", rxif.rx_data, 0);
    chk("mid_rst_err", rx_err, 0);
    chk("mid_rst_code", rx_err_code, 0);
    chk("mid_rst_busy", busy, 0);
    rxif.rx_ready = 1'b1;
    h_cyc(1'b0);
    burst(8'hFF, 2, 1'b1, 1'b0);
    chk("after_rst_drained", rxif.rx_valid, 0);

    // Overflow: five bursts into a 4-deep FIFO with the consumer stalled.
    rxif.rx_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) err_q.push_back(2'd0);
      burst(8'(k), 2, (k <= 4), 1'b0);
    end
    chk("ovf_code", rx_err_code, 0);
    chk("ovf_head", rxif.rx_data, 8'h01);
    rxif.rx_ready = 1'b1;
    repeat (3) h_cyc(1'b0);
    chk("drain_one_left", rxif.rx_valid, 1);
    h_cyc(1'b0);
    chk("drain_empty", rxif.rx_valid, 0);

    repeat (4) h_cyc(1'b0);
    chk("bytes_outstanding", exp_q.size(), 0);
    chk("errs_outstanding", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dq_rx.md
# dq_rx

Single-clock receiver that sits downstream of the `comp` serial transmitter on the shared `dqs_p`/`dqs_n`/`dq` nets inside `rank`. It samples the strobe pair and data line, recognises preamble, 8-bit burst and postamble, and reassembles each burst into a byte. It rejects malformed bursts with an error code and buffers completed bytes in a small FIFO with a valid/ready output.

## Interface
- `DEPTH`, 4, FIFO depth in bytes; power of 2, ≥2.
- `PRE_MIN`, 2, minimum preamble length in clk cycles.
- `TIMEOUT`, 64, maximum clk cycles without a strobe level change inside a burst.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dqs_p`  in  1  strobe, true leg; read-only tap of the inout net.
- `dqs_n`  in  1  strobe, complement leg; read-only tap of the inout net.
- `dq`  in  1  serial data; read-only tap of the inout net.
- `rx_data`  out  8  head-of-FIFO byte; first-word fall-through.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `rx_err`  out  1  one-cycle error pulse.
- `rx_err_code`  out  2  0=overflow, 1=short preamble, 2=strobe contention, 3=timeout; holds last code.
- `busy`  out  1  FSM not in IDLE.

## Operation
- All three inputs are registered once: `s_p`, `s_n`, `s_dq`. The FSM acts only on the registered values.
- Strobe level decode: H = (`s_p`=1, `s_n`=0); L = (0,1); X = any other combination. Idle bus is H because of the net pullup/pulldown.
- Wire protocol:
  - Preamble: L for ≥`PRE_MIN` cycles.
  - Data: 8 bits, MSB first. Each bit is an L→H transition with `dq` valid in the H cycle; strobe returns to L between bits.
  - Postamble: L after bit 8, then release to H.
- States:
  - IDLE: H or X → stay; X is not an error here. L → PRE, `lvl_cnt` = 1.
  - PRE: L → `lvl_cnt`++. H with `lvl_cnt` ≥ `PRE_MIN` → shift `s_dq` into the shift register as bit 7, set `bit_cnt` = 1, go BIT_HI. H with `lvl_cnt` < `PRE_MIN` → error code 1, go IDLE.
  - BIT_HI: H → stay. L → BIT_LO.
  - BIT_LO: L → stay. H → shift `s_dq` in, `bit_cnt`++. If `bit_cnt` becomes 8 → push the byte and go POST; else go BIT_HI.
  - POST: first waits for L (postamble), then H → IDLE. H seen before any L: stay in POST; that H is the continuation of bit 8.
- In every state except IDLE:
  - X → error code 2, discard partial byte, go IDLE.
  - `lvl_cnt` counts cycles since the last level change. Reaching `TIMEOUT` → error code 3, discard partial byte, go IDLE.
- FIFO:
  - `DEPTH` entries; pointers are log2(`DEPTH`)+1 bits and wrap modulo 2·`DEPTH`.
  - A push while full is dropped and raises error code 0, except that push and pop in the same cycle while full is legal: the occupancy stays `DEPTH`.
  - A pop while empty is ignored.
  - `rx_data` is a don't-care when `rx_valid`=0 and is driven as 0 after reset.
- Only one error can occur per cycle, so error priority is moot. Overflow and an FSM error never coincide, because a push happens only on a successful bit 8.

## Timing
- Reset values:
  - `s_p`=1, `s_n`=0, `s_dq`=0, FSM in IDLE, counters 0.
  - FIFO empty; `rx_valid`=0, `rx_data`=0, `rx_err`=0, `rx_err_code`=0, `busy`=0.
- Reset asserted mid-burst or with bytes pending: all bytes are lost, and no error is flagged.
- Latency: the 8th rising strobe on the pins at cycle t is registered at t+1 and the FSM pushes at the end of t+1. `rx_valid` rises at t+2, with the byte on `rx_data`, if the FIFO was empty.
- `rx_err` pulses in the cycle after the FSM detects the condition, i.e. 2 clk after the offending pin value. `rx_err_code` updates in the same cycle.
- `busy` goes high 2 clk after L first appears on the pins. It goes low 2 clk after the release-to-H.
- Pop takes effect at the clock edge where `rx_valid && rx_ready`; the next entry is presented the following cycle.

## Test plan
- Clean burst, preamble 2 cycles, 2-cycle bit periods, byte 0xA5 → `rx_valid` 2 clk after bit 8, `rx_data`=0xA5, no `rx_err`, `busy` drops after release.
- Preamble of 1 cycle, then H → `rx_err` with code 1, `rx_valid` stays 0, FSM back in IDLE.
- Force `dqs_p`=`dqs_n`=1 after bit 3 → code 2, partial byte discarded; the next clean burst of 0x3C is received correctly.
- Hold L for 64 cycles in BIT_LO → code 3 on the 64th cycle; no byte is pushed.
- `rx_ready`=0, five bursts 0x01..0x05 with `DEPTH`=4 → 4 bytes stored, 5th raises code 0. Raising `rx_ready` drains 0x01..0x04 in order, one per cycle.
- Assert `rst` for 1 cycle during bit 5, with 2 bytes queued → all outputs return to reset values; a subsequent burst of 0xFF is received alone.
